hilo_div_unit: RTL and testbench

//  Multi-cycle signed divider that owns the HI/LO registers for the pipelined MIPS core.
//  It is driven by the decoder's div and mf controls in the EX stage.
//  It sequences one DIV over WIDTH+2 cycles and serves MFHI/MFLO reads.
//  It raises a stall to the hazard logic while a result is pending.

---
 rtl/hilo_div_unit_pkg.sv | 22 ++
 rtl/hilo_div_unit_if.sv | 32 +++
 rtl/hilo_div_unit_div_step.sv | 27 ++
 rtl/hilo_div_unit.sv | 137 +++++++++++++
 tb/tb_hilo_div_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/hilo_div_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_div_unit_pkg
//  Description : Shared state codes and move-from encodings for the HI/LO
//                divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package hilo_div_unit_pkg;

    typedef enum logic [1:0] {
        HD_IDLE = 2'b00,
        HD_RUN  = 2'b01,
        HD_FIX  = 2'b10
    } hd_state_t;

    // Same encoding as the decoder's mf output.
    localparam logic [1:0] c_mf_none = 2'b00;
    localparam logic [1:0] c_mf_hi   = 2'b10;
    localparam logic [1:0] c_mf_lo   = 2'b11;

endpackage
`default_nettype wire

// File: rtl/hilo_div_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_div_unit_if
//  Description : EX-stage control/data bundle between the pipeline and the
//                HI/LO divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
interface hilo_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             div_start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [1:0]       mf;
    logic [WIDTH-1:0] mf_data;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;
    logic             div_by_zero;

    modport master (
        output div_start, dividend, divisor, mf,
        input  mf_data, hi, lo, busy, stall, div_by_zero
    );

    modport slave (
        input  div_start, dividend, divisor, mf,
        output mf_data, hi, lo, busy, stall, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/hilo_div_unit_div_step.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_div_unit_div_step
//  Description : One combinational restoring-division step on {rem,quo}.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_div_unit_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    assign w_shift = {rem, quo[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, dvs};

    // A clear sign bit on the trial means the divisor fit: keep it, set q bit.
    assign rem_nxt = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign quo_nxt = {quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule
`default_nettype wire

// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_div_unit
//  Description : Multi-cycle signed divider owning HI/LO, with MFHI/MFLO reads
//                and a stall output for the hazard logic.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    hilo_div_unit_if.slave     bus
);
    localparam logic [CNT_W-1:0] c_cnt_init = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(1);
    localparam logic [WIDTH-1:0] c_zero     = {WIDTH{1'b0}};

    hd_state_t        r_state;
    hd_state_t        w_state_nxt;
    logic             w_load;
    logic             w_fix;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_dividend;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_zero;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;

    assign w_dvd_mag = bus.dividend[WIDTH-1] ? (c_zero - bus.dividend) : bus.dividend;
    assign w_dvs_mag = bus.divisor[WIDTH-1]  ? (c_zero - bus.divisor)  : bus.divisor;

    hilo_div_unit_div_step #(
        .WIDTH   (WIDTH)
    ) u_div_step (
        .rem     (r_rem),
        .quo     (r_quo),
        .dvs     (r_dvs),
        .rem_nxt (w_rem_nxt),
        .quo_nxt (w_quo_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= HD_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_load          = 1'b0;
        w_fix           = 1'b0;
        bus.busy        = (r_state != HD_IDLE);
        bus.div_by_zero = 1'b0;
        case (r_state)
            HD_IDLE: begin
                if (bus.div_start) begin
                    w_state_nxt = HD_RUN;
                    w_load      = 1'b1;
                end
            end
            HD_RUN: begin
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = HD_FIX;
                end
            end
            HD_FIX: begin
                w_state_nxt     = HD_IDLE;
                w_fix           = 1'b1;
                bus.div_by_zero = r_zero;
            end
            default: w_state_nxt = HD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quo      <= '0;
            r_dvs      <= '0;
            r_dividend <= '0;
            r_q_neg    <= 1'b0;
            r_r_neg    <= 1'b0;
            r_zero     <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            if (w_load) begin
                r_cnt      <= c_cnt_init;
                r_rem      <= '0;
                r_quo      <= w_dvd_mag;
                r_dvs      <= w_dvs_mag;
                r_dividend <= bus.dividend;
                r_q_neg    <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                r_r_neg    <= bus.dividend[WIDTH-1];
                r_zero     <= (bus.divisor == c_zero);
            end else if (r_state == HD_RUN) begin
                r_cnt <= r_cnt - c_cnt_last;
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
            end
            // A zero divisor leaves the dividend in HI and all-ones in LO.
            if (w_fix) begin
                if (r_zero) begin
                    r_hi <= r_dividend;
                    r_lo <= {WIDTH{1'b1}};
                end else begin
                    r_hi <= r_r_neg ? (c_zero - r_rem) : r_rem;
                    r_lo <= r_q_neg ? (c_zero - r_quo) : r_quo;
                end
            end
        end
    end

    assign bus.hi      = r_hi;
    assign bus.lo      = r_lo;
    assign bus.mf_data = bus.mf[1] ? (bus.mf[0] ? r_lo : r_hi) : c_zero;
    assign bus.stall   = bus.busy & (bus.mf[1] | bus.div_start);

endmodule
`default_nettype wire

// File: tb/tb_hilo_div_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_div_unit
//  Description : Randomized and directed bench for hilo_div_unit against a
//                signed-arithmetic reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_div_unit;
    import hilo_div_unit_pkg::*;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hilo_div_unit_if #(.WIDTH(WIDTH)) bus ();

    hilo_div_unit #(
        .WIDTH (WIDTH),
        .CNT_W (6)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Signed truncating division; remainder takes the dividend's sign.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'h0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        bus.dividend  = a;
        bus.divisor   = b;
        bus.div_start = 1'b1;
        #1;
        chk("issue_busy", bus.busy, 0);
        chk("issue_stall", bus.stall, 0);
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input bit stall_exp, output int nb, output int nz);
        nb = 0;
        nz = 0;
        #1;
        while (bus.busy === 1'b1 && nb < 200) begin
            nb++;
            if (bus.div_by_zero === 1'b1) nz++;
            if (stall_exp) chk("stall_busy", bus.stall, 1);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input bit hold_lo);
        logic [31:0] q, r;
        int nb, nz;
        ref_div(a, b, q, r);
        issue(a, b);
        bus.div_start = 1'b0;
        if (hold_lo) bus.mf = c_mf_lo;
        wait_idle(hold_lo, nb, nz);
        chk("busy_cycles", nb, WIDTH + 1);
        chk("dbz_pulses", nz, (b == 32'h0) ? 1 : 0);
        chk("lo", bus.lo, q);
        chk("hi", bus.hi, r);
        if (hold_lo) begin
            chk("mflo_unstall", bus.stall, 0);
            chk("mflo_data", bus.mf_data, q);
            bus.mf = c_mf_none;
        end
    endtask

    initial begin
        logic [31:0] q1, r1, q2, r2, a, b;
        int nb, nz;

        rst           = 1'b1;
        bus.div_start = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.mf        = c_mf_none;
        #1;
        chk("rst_hi", bus.hi, 0);
        chk("rst_lo", bus.lo, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dbz", bus.div_by_zero, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        do_div(32'd100, 32'd7, 1'b0);
        do_div(-32'sd100, 32'd7, 1'b0);
        do_div(32'd100, -32'sd7, 1'b0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_div(32'd5, 32'd0, 1'b0);
        do_div(-32'sd9, 32'd1, 1'b0);
        do_div(32'd100, 32'd7, 1'b1);

        bus.mf = c_mf_hi;
        #1;
        chk("mfhi_stall", bus.stall, 0);
        chk("mfhi_data", bus.mf_data, 32'd2);
        bus.mf = 2'b01;
        #1;
        chk("mf_none_data", bus.mf_data, 0);

        // MFLO in the same idle cycle as a new DIV sees the old quotient.
        bus.mf        = c_mf_lo;
        bus.dividend  = 32'd9;
        bus.divisor   = 32'd3;
        bus.div_start = 1'b1;
        #1;
        chk("mf_same_cycle", bus.mf_data, 32'd14);
        chk("mf_same_stall", bus.stall, 0);
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        bus.mf        = c_mf_none;
        wait_idle(1'b0, nb, nz);
        chk("same_lo", bus.lo, 32'd3);

        // Async reset in the middle of an iteration discards the divide.
        do_div(32'd100, 32'd7, 1'b0);
        issue(32'd1000, 32'd3);
        bus.div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("pre_rst_busy", bus.busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_hi", bus.hi, 0);
        chk("mid_rst_lo", bus.lo, 0);
        chk("mid_rst_busy", bus.busy, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_div(32'd9, 32'd3, 1'b0);

        // Second DIV held during busy issues in the first idle cycle.
        ref_div(32'd1234, -32'sd17, q1, r1);
        ref_div(-32'sd5000, 32'd33, q2, r2);
        issue(32'd1234, -32'sd17);
        bus.dividend = -32'sd5000;
        bus.divisor  = 32'd33;
        wait_idle(1'b1, nb, nz);
        chk("b2b_first_cycles", nb, WIDTH + 1);
        chk("b2b_first_lo", bus.lo, q1);
        chk("b2b_first_hi", bus.hi, r1);
        chk("b2b_idle_stall", bus.stall, 0);
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        wait_idle(1'b0, nb, nz);
        chk("b2b_second_cycles", nb, WIDTH + 1);
        chk("b2b_second_lo", bus.lo, q2);
        chk("b2b_second_hi", bus.hi, r2);

        repeat (24) begin
            a = $urandom;
            case ($urandom_range(0, 4))
                0: b = $urandom;
                1: b = $urandom_range(1, 15);
                2: b = -$urandom_range(1, 15);
                3: b = $urandom & 32'h0000_FFFF;
                default: b = 32'h0;
            endcase
            do_div(a, b, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
